// File: rtl/mole_hit_judge.sv
// Judges each whack-a-mole round as hit, wrong press or escaped mole, and keeps
// saturating hit/miss counters plus single-cycle strobes for the score path.
module mole_hit_judge #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned SCORE_MAX = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mole_pattern,
    input  logic [WIDTH-1:0] button_db,
    input  logic             game_active,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [7:0]       score,
    output logic [7:0]       misses,
    output logic             armed
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StArmed  = 2'd2;
    localparam logic [1:0] StJudged = 2'd3;

    localparam logic [7:0] ScoreMax = SCORE_MAX[7:0];

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] btn_q, pat_q;
    logic             act_q;
    logic             hit_q, miss_q, armed_q;
    logic [7:0]       score_q, score_d, misses_q, misses_d;

    logic [WIDTH-1:0] press_edge;
    logic             chg, new_lit, hit, miss;

    always_comb begin
        press_edge = button_db & ~btn_q;
        chg        = (mole_pattern != pat_q);
        new_lit    = |mole_pattern;
        hit        = 1'b0;
        miss       = 1'b0;
        state_d    = state_q;
        score_d    = score_q;
        misses_d   = misses_q;

        case (state_q)
            StIdle: begin
                if (game_active && !act_q) begin
                    score_d  = 8'd0;
                    misses_d = 8'd0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (chg && new_lit) state_d = StArmed;
            end
            StArmed: begin
                // Judge against pat_q, the pattern the player actually saw.
                // On the game-stop cycle only presses count, not the mole going dark.
                hit  = |(press_edge & pat_q);
                miss = !hit && ((|press_edge) || (chg && game_active));
                if (chg)      state_d = new_lit ? StArmed : StWait;
                else if (hit) state_d = StJudged;
            end
            StJudged: begin
                if (chg) state_d = new_lit ? StArmed : StWait;
            end
            default: state_d = StIdle;
        endcase

        if (hit && (score_q < ScoreMax))   score_d  = score_q + 8'd1;
        if (miss && (misses_q < ScoreMax)) misses_d = misses_q + 8'd1;

        if (!game_active) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            btn_q    <= '0;
            pat_q    <= '0;
            act_q    <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            armed_q  <= 1'b0;
            score_q  <= 8'd0;
            misses_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            btn_q    <= button_db;
            pat_q    <= mole_pattern;
            act_q    <= game_active;
            hit_q    <= hit;
            miss_q   <= miss;
            armed_q  <= (state_d == StArmed);
            score_q  <= score_d;
            misses_q <= misses_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign armed      = armed_q;

endmodule
